// File: rtl/wb_shared_bus_dec.sv
// One-master / N-slave Wishbone Classic shared bus with address-field decode,
// per-strobe slave locking, ACK watchdog, decode/timeout ERR and a saturating error counter.
module wb_shared_bus_dec #(
    parameter int N       = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int SEL_LSB = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_cyc,
    input  logic            m_stb,
    input  logic            m_we,
    input  logic [AW-1:0]   m_addr,
    input  logic [DW-1:0]   m_dat_w,
    output logic [DW-1:0]   m_dat_r,
    output logic            m_ack,
    output logic            m_err,
    output logic [N-1:0]    s_cyc,
    output logic [N-1:0]    s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_dat_w,
    input  logic [N*DW-1:0] s_dat_r,
    input  logic [N-1:0]    s_ack,
    output logic [7:0]      err_cnt
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    // IDLE: decode and strobe with zero latency | ACTIVE: locked to sel_q, watchdog running
    // ERR: one-cycle error response to master
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [7:0]    wdog_q, wdog_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [SW-1:0] dec;
    logic          valid;
    logic          strobe;
    logic [DW-1:0] slv_dat [N];

    for (genvar i = 0; i < N; i++) begin : g_dat
        assign slv_dat[i] = s_dat_r[i*DW +: DW];
    end

    assign dec     = m_addr[SEL_LSB +: SW];
    assign valid   = (32'(dec) < 32'(N));
    // Reset also blanks the combinational strobe path so nothing reaches a slave during reset.
    assign strobe  = m_cyc & m_stb & rst_n;
    assign s_we    = m_we;
    assign s_addr  = m_addr;
    assign s_dat_w = m_dat_w;
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            wdog_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wdog_q    <= wdog_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wdog_d    = wdog_q;
        err_cnt_d = err_cnt_q;
        s_cyc     = '0;
        s_stb     = '0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_dat_r   = '0;
        case (state_q)
            ST_IDLE: begin
                if (valid) m_dat_r = slv_dat[dec];
                if (strobe && valid) begin
                    s_cyc[dec] = 1'b1;
                    s_stb[dec] = 1'b1;
                    sel_d      = dec;
                    if (s_ack[dec]) begin
                        m_ack  = 1'b1;
                        wdog_d = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                        wdog_d  = 8'd1;
                    end
                end else if (strobe) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACTIVE: begin
                s_cyc[sel_q] = m_cyc & rst_n;
                s_stb[sel_q] = strobe;
                m_dat_r      = slv_dat[sel_q];
                if (!strobe) begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end else if (s_ack[sel_q]) begin
                    // An ack on the timeout cycle still completes the transfer.
                    m_ack   = 1'b1;
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end else if (wdog_q == 8'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            ST_ERR: begin
                m_err   = 1'b1;
                state_d = ST_IDLE;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
